hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage core: detects load-use and branch/jr operand hazards, holds the front end for the exact number of bubble cycles, kills the wrong-path fetch on taken control transfers, and sequences the multi-cycle multiply/divide unit (MDU) by stalling HI/LO consumers and back-to-back MDU issues. It sits beside the forwarding unit, consuming the same ID/EX/MEM register identifiers, and drives the PC, IF/ID and ID/EX pipeline-register controls. Its stalls guarantee every remaining dependency is coverable by forwarding or by the register-file write-through.

## Interface
- MDU_LATENCY, 32: MDU busy cycles after an accepted start (≥1).
- CNT_W, $clog2(MDU_LATENCY+1): MDU counter width.

- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- ID_Rs, ID_Rt  in  5  source registers of the instruction in ID.
- ID_UseRs, ID_UseRt  in  1  ID instruction actually reads Rs / Rt in EX.
- ID_Branch  in  1  conditional branch in ID (reads Rs, Rt in ID).
- ID_PCSrc  in  2  PC select; bit1 = jr/jalr (reads Rs in ID); nonzero = jump.
- ID_BranchTaken  in  1  branch comparator result in ID.
- ID_MduStart  in  1  mult/div in ID.
- ID_HiLoRead  in  1  mfhi/mflo in ID.
- EX_RegWrite, EX_MemRead  in  1  EX instruction writes a register / is a load.
- EX_WriteReg  in  5  EX destination.
- MEM_MemRead  in  1  MEM instruction is a load.
- MEM_WriteReg  in  5  MEM destination.
- PC_Write  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- IF_ID_Flush  out  1  clear IF/ID to nop.
- ID_EX_Bubble  out  1  load nop into ID/EX.
- MDU_Busy  out  1  MDU result not yet valid.

## Operation
- Register 0 never creates a hazard.
- Stall = PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
- Hazards evaluated in state RUN (combinational on inputs + state):
  - Load-use: EX_MemRead, EX_WriteReg matches a used ID source → 1 bubble.
  - Control-on-ALU: (ID_Branch or ID_PCSrc[1]) with EX_RegWrite, not EX_MemRead, EX_WriteReg matching a control-read source → 1 bubble.
  - Control-on-EX-load: same as above with EX_MemRead → 2 bubbles.
  - Control-on-MEM-load: MEM_MemRead, MEM_WriteReg matching a control-read source → 1 bubble.
  - MDU: (ID_HiLoRead or ID_MduStart) while MDU_Busy → stall, re-evaluated each cycle.
- FSM: RUN, HOLD1. RUN with a 2-bubble hazard → stall, go HOLD1. HOLD1 → stall unconditionally, ignore all hazard inputs, go RUN. All other hazards stall in RUN and stay in RUN.
- Flush: in RUN with no stall, (ID_Branch and ID_BranchTaken) or ID_PCSrc≠0 → IF_ID_Flush=1; PC_Write=1, IF_ID_Write=1. Stall always masks flush.
- MDU counter: ID_MduStart accepted only in a non-stall cycle → counter := MDU_LATENCY; else decrement if nonzero. MDU_Busy = (counter≠0).
- Multiple causes in one cycle: single stall; no cause ever increases bubble count beyond its own maximum.

## Timing
- Reset (rst_n low, async): state RUN, counter 0; outputs PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, MDU_Busy=0, forced regardless of inputs.
- Reset mid-HOLD1 or mid-MDU: both abandoned; first cycle after release is RUN, not busy.
- Control outputs are combinational, same-cycle with detection; state/counter update on clk rising edge.
- MDU: start accepted at edge N → MDU_Busy high for cycles N+1 … N+MDU_LATENCY; HI/LO read stalled through that window, proceeds in cycle N+MDU_LATENCY+1.
- Control-on-EX-load: detect cycle t (bubble), t+1 HOLD1 (bubble), branch resolves in t+2 via register-file write-through.

## Structure
- Shared pipeline package: FSM state encoding, PCSrc encodings (jump, jr bit), nop/bubble constant.
- Sub-module mdu_sequencer: counter, accept logic, MDU_Busy; top keeps hazard detect, FSM and output mux.

## Test plan
- lw $t0 in EX, add using $t0 in ID → one cycle ID_EX_Bubble=1, PC_Write=0; next cycle no stall.
- lw $t1 in EX, beq $t1,$t2 in ID → two consecutive stall cycles (RUN→HOLD1→RUN), then branch taken raises IF_ID_Flush=1 for one cycle.
- add $t3 in EX, jr $t3 in ID → one stall; next cycle IF_ID_Flush=1; EX_WriteReg=0 with match → no stall.
- MDU_LATENCY=4: mult accepted, mflo next cycle → MDU_Busy high 4 cycles, mflo stalled 4 cycles, issues cycle 5.
- Load-use coincident with mult in ID → mult not accepted, MDU_Busy stays 0 that cycle, accepted next cycle.
- rst_n pulse low during HOLD1 with counter=3 → outputs at reset values immediately; after release RUN, MDU_Busy=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline encodings for the hazard controller
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_HOLD1 = 1'b1
  } hz_state_t;

  localparam logic [1:0]  PCSRC_SEQ    = 2'b00;
  localparam int          PCSRC_JR_BIT = 1;
  localparam logic [4:0]  REG_ZERO     = 5'd0;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  // A source only depends on a producer when it is really read and is not $zero.
  function automatic logic reg_hit(input logic rd, input logic [4:0] src, input logic [4:0] dst);
    return rd && (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID/EX/MEM hazard inputs and front-end control outputs
interface hazard_ctrl_if;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_UseRs;
  logic       ID_UseRt;
  logic       ID_Branch;
  logic [1:0] ID_PCSrc;
  logic       ID_BranchTaken;
  logic       ID_MduStart;
  logic       ID_HiLoRead;
  logic       EX_RegWrite;
  logic       EX_MemRead;
  logic [4:0] EX_WriteReg;
  logic       MEM_MemRead;
  logic [4:0] MEM_WriteReg;
  logic       PC_Write;
  logic       IF_ID_Write;
  logic       IF_ID_Flush;
  logic       ID_EX_Bubble;
  logic       MDU_Busy;

  modport master (
    output ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Branch, ID_PCSrc, ID_BranchTaken,
           ID_MduStart, ID_HiLoRead, EX_RegWrite, EX_MemRead, EX_WriteReg,
           MEM_MemRead, MEM_WriteReg,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MDU_Busy
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UseRs, ID_UseRt, ID_Branch, ID_PCSrc, ID_BranchTaken,
           ID_MduStart, ID_HiLoRead, EX_RegWrite, EX_MemRead, EX_WriteReg,
           MEM_MemRead, MEM_WriteReg,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, MDU_Busy
  );
endinterface

// File: rtl/hazard_ctrl_mdu_sequencer.sv
// rtl/hazard_ctrl_mdu_sequencer.sv - multiply/divide busy counter
module mdu_sequencer #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = $clog2(MDU_LATENCY + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stall,
  output logic busy
);

  logic [CNT_W-1:0] cnt_q;

  // A start presented during a stall is not taken; ID retries it next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start && !stall) begin
      cnt_q <= CNT_W'(MDU_LATENCY);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / control-operand / MDU hazard detection and front-end control
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = $clog2(MDU_LATENCY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  hz_state_t state_q, state_d;
  logic      stall, flush, mdu_busy;
  logic      ctl_rs, ctl_rt, ex_ctrl_hit, mem_ctrl_hit, ex_use_hit;
  logic      load_use, ctrl_alu, ctrl_exload, ctrl_memload, mdu_hazard, redirect;

  // Branches read both operands in ID; jr/jalr read only Rs.
  assign ctl_rs = bus.ID_Branch || bus.ID_PCSrc[PCSRC_JR_BIT];
  assign ctl_rt = bus.ID_Branch;

  assign ex_use_hit   = reg_hit(bus.ID_UseRs, bus.ID_Rs, bus.EX_WriteReg)
                     || reg_hit(bus.ID_UseRt, bus.ID_Rt, bus.EX_WriteReg);
  assign ex_ctrl_hit  = reg_hit(ctl_rs, bus.ID_Rs, bus.EX_WriteReg)
                     || reg_hit(ctl_rt, bus.ID_Rt, bus.EX_WriteReg);
  assign mem_ctrl_hit = reg_hit(ctl_rs, bus.ID_Rs, bus.MEM_WriteReg)
                     || reg_hit(ctl_rt, bus.ID_Rt, bus.MEM_WriteReg);

  assign load_use     = bus.EX_MemRead && ex_use_hit;
  assign ctrl_alu     = bus.EX_RegWrite && !bus.EX_MemRead && ex_ctrl_hit;
  assign ctrl_exload  = bus.EX_RegWrite && bus.EX_MemRead && ex_ctrl_hit;
  assign ctrl_memload = bus.MEM_MemRead && mem_ctrl_hit;
  assign mdu_hazard   = (bus.ID_HiLoRead || bus.ID_MduStart) && mdu_busy;
  assign redirect     = (bus.ID_Branch && bus.ID_BranchTaken) || (bus.ID_PCSrc != PCSRC_SEQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall = load_use || ctrl_alu || ctrl_exload || ctrl_memload || mdu_hazard;
        if (ctrl_exload) begin
          state_d = ST_HOLD1;
        end
        flush = !stall && redirect;
      end
      ST_HOLD1: begin
        // Second bubble for a branch on an EX load; inputs are stale here.
        stall   = 1'b1;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  mdu_sequencer #(
    .MDU_LATENCY (MDU_LATENCY),
    .CNT_W       (CNT_W)
  ) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.ID_MduStart),
    .stall (stall),
    .busy  (mdu_busy)
  );

  // Outputs are held at their idle values while reset is asserted.
  assign bus.PC_Write     = !rst_n || !stall;
  assign bus.IF_ID_Write  = !rst_n || !stall;
  assign bus.ID_EX_Bubble = rst_n && stall;
  assign bus.IF_ID_Flush  = rst_n && flush;
  assign bus.MDU_Busy     = mdu_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against a bubble-count model
module tb_hazard_ctrl;

  localparam int LAT = 4;

  typedef struct {
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, branch;
    logic [1:0] pcsrc;
    logic       taken, mdu_start, hilo_read;
    logic       ex_regwrite, ex_memread;
    logic [4:0] ex_wr;
    logic       mem_memread;
    logic [4:0] mem_wr;
  } stim_t;

  typedef struct {
    int   cyc;
    logic pc_write, ifid_write, flush, bubble, busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MDU_LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif.slave)
  );

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   m_hold = 0;
  int   m_rem = 0;

  function automatic stim_t nop();
    stim_t s;
    s = '{rs:0, rt:0, use_rs:0, use_rt:0, branch:0, pcsrc:0, taken:0, mdu_start:0,
          hilo_read:0, ex_regwrite:0, ex_memread:0, ex_wr:0, mem_memread:0, mem_wr:0};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rs          = 5'($urandom_range(0, 3));
    s.rt          = 5'($urandom_range(0, 3));
    s.use_rs      = 1'($urandom);
    s.use_rt      = 1'($urandom);
    s.branch      = ($urandom_range(0, 3) == 0);
    s.pcsrc       = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
    s.taken       = 1'($urandom);
    s.mdu_start   = ($urandom_range(0, 5) == 0);
    s.hilo_read   = ($urandom_range(0, 3) == 0);
    s.ex_memread  = ($urandom_range(0, 2) == 0);
    s.ex_regwrite = s.ex_memread || 1'($urandom);
    s.ex_wr       = 5'($urandom_range(0, 3));
    s.mem_memread = ($urandom_range(0, 2) == 0);
    s.mem_wr      = 5'($urandom_range(0, 3));
    return s;
  endfunction

  // Bubbles this instruction needs in ID, as the largest requirement of any single cause.
  function automatic int bubbles_needed(stim_t s, int rem);
    int  b = 0;
    bit  ctl_rs = (s.branch || s.pcsrc[1]) && s.rs != 0;
    bit  ctl_rt = s.branch && s.rt != 0;
    bit  use_rs = s.use_rs && s.rs != 0;
    bit  use_rt = s.use_rt && s.rt != 0;
    bit  ex_ctl = (ctl_rs && s.rs == s.ex_wr) || (ctl_rt && s.rt == s.ex_wr);
    if (s.ex_memread && ((use_rs && s.rs == s.ex_wr) || (use_rt && s.rt == s.ex_wr))) b = (b > 1) ? b : 1;
    if (s.ex_regwrite && ex_ctl) b = s.ex_memread ? 2 : ((b > 1) ? b : 1);
    if (s.mem_memread && ((ctl_rs && s.rs == s.mem_wr) || (ctl_rt && s.rt == s.mem_wr))) b = (b > 1) ? b : 1;
    if ((s.hilo_read || s.mdu_start) && rem > 0) b = (b > 1) ? b : 1;
    return b;
  endfunction

  task automatic apply(stim_t s);
    hif.ID_Rs = s.rs;               hif.ID_Rt = s.rt;
    hif.ID_UseRs = s.use_rs;        hif.ID_UseRt = s.use_rt;
    hif.ID_Branch = s.branch;       hif.ID_PCSrc = s.pcsrc;
    hif.ID_BranchTaken = s.taken;   hif.ID_MduStart = s.mdu_start;
    hif.ID_HiLoRead = s.hilo_read;  hif.EX_RegWrite = s.ex_regwrite;
    hif.EX_MemRead = s.ex_memread;  hif.EX_WriteReg = s.ex_wr;
    hif.MEM_MemRead = s.mem_memread; hif.MEM_WriteReg = s.mem_wr;
  endtask

  task automatic drive(stim_t s, logic r);
    exp_t x;
    int   b;
    bit   stall;
    @(posedge clk);
    #1;
    rst_n = r;
    apply(s);
    cyc++;
    x.cyc = cyc;
    if (!r) begin
      m_hold = 0;
      m_rem  = 0;
      x.pc_write = 1; x.ifid_write = 1; x.flush = 0; x.bubble = 0; x.busy = 0;
    end else begin
      b     = (m_hold > 0) ? 0 : bubbles_needed(s, m_rem);
      stall = (m_hold > 0) || (b > 0);
      x.pc_write   = !stall;
      x.ifid_write = !stall;
      x.bubble     = stall;
      x.busy       = (m_rem > 0);
      x.flush      = !stall && ((s.branch && s.taken) || s.pcsrc != 0);
      m_hold = (m_hold > 0) ? m_hold - 1 : ((b > 0) ? b - 1 : 0);
      if (s.mdu_start && !stall) m_rem = LAT;
      else if (m_rem > 0)        m_rem = m_rem - 1;
    end
    exp_q.push_back(x);
  endtask

  task automatic chk(string name, logic got, logic want, int c);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0b expected %0b", name, c, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("PC_Write",     hif.PC_Write,     e.pc_write,   e.cyc);
      chk("IF_ID_Write",  hif.IF_ID_Write,  e.ifid_write, e.cyc);
      chk("IF_ID_Flush",  hif.IF_ID_Flush,  e.flush,      e.cyc);
      chk("ID_EX_Bubble", hif.ID_EX_Bubble, e.bubble,     e.cyc);
      chk("MDU_Busy",     hif.MDU_Busy,     e.busy,       e.cyc);
    end
  end

  initial begin
    stim_t s;
    apply(nop());
    // Reset with a load-use pattern present: outputs must still sit at idle values.
    s = nop(); s.ex_memread = 1; s.ex_regwrite = 1; s.ex_wr = 8; s.rs = 8; s.use_rs = 1;
    drive(s, 0);
    drive(nop(), 0);
    // Load-use: one bubble, then free.
    drive(s, 1);
    s = nop(); s.rs = 8; s.use_rs = 1;
    drive(s, 1);
    // Branch on EX load: two bubbles, then taken branch flushes.
    s = nop(); s.branch = 1; s.taken = 1; s.rs = 9; s.rt = 10;
    s.ex_memread = 1; s.ex_regwrite = 1; s.ex_wr = 9;
    drive(s, 1);
    s.ex_memread = 0; s.ex_regwrite = 0; s.ex_wr = 0;
    drive(s, 1);
    drive(s, 1);
    // jr on ALU result: one stall then flush; $zero destination never stalls.
    s = nop(); s.pcsrc = 2'b10; s.rs = 11; s.ex_regwrite = 1; s.ex_wr = 11;
    drive(s, 1);
    s.ex_regwrite = 0;
    drive(s, 1);
    s = nop(); s.pcsrc = 2'b10; s.rs = 0; s.ex_regwrite = 1; s.ex_wr = 0;
    drive(s, 1);
    // MEM load feeding a branch: one bubble.
    s = nop(); s.branch = 1; s.rt = 12; s.mem_memread = 1; s.mem_wr = 12;
    drive(s, 1);
    // mult then mflo: busy LAT cycles, mflo stalled through them.
    s = nop(); s.mdu_start = 1;
    drive(s, 1);
    s = nop(); s.hilo_read = 1;
    for (int i = 0; i < LAT + 1; i++) drive(s, 1);
    // Load-use coincident with mult: not accepted until the stall clears.
    s = nop(); s.mdu_start = 1; s.use_rt = 1; s.rt = 13;
    s.ex_memread = 1; s.ex_regwrite = 1; s.ex_wr = 13;
    drive(s, 1);
    s.ex_memread = 0; s.ex_regwrite = 0;
    drive(s, 1);
    for (int i = 0; i < LAT; i++) drive(nop(), 1);
    // Reset pulse during HOLD1 with the MDU mid-flight.
    s = nop(); s.mdu_start = 1;
    drive(s, 1);
    s = nop(); s.branch = 1; s.rs = 14; s.ex_memread = 1; s.ex_regwrite = 1; s.ex_wr = 14;
    drive(s, 1);
    s = nop(); s.hilo_read = 1;
    drive(s, 0);
    drive(s, 1);
    drive(s, 1);
    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 600; i++) drive(rnd(), ($urandom_range(0, 79) != 0));
    drive(nop(), 1);
    @(posedge clk);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
